// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker: four shared rate dividers drive NUM_CH channels in off/on/blink/burst mode.
// Latency: led updates one clock after the divider strobe, or one clock after a mode/rate change.
// Backpressure: none; free-running output stage, enable low parks every LED dark and restarts the dividers.
module led_blink_multi #(
    parameter int unsigned RATE_HALF0 = 125_000,
    parameter int unsigned RATE_HALF1 = 250_000,
    parameter int unsigned RATE_HALF2 = 1_250_000,
    parameter int unsigned RATE_HALF3 = 12_500_000,
    parameter int          CNT_W      = 32,
    parameter int          NUM_CH     = 4,
    parameter int          BURST_LEN  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [2*NUM_CH-1:0]   rate_sel,
    input  logic [2*NUM_CH-1:0]   mode,
    output logic [NUM_CH-1:0]     led
);

    // Burst cycle: BURST_LEN on/off pairs followed by an equally long dark gap.
    localparam int PH_N = 4 * BURST_LEN;
    localparam int PH_W = $clog2(PH_N);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(PH_N - 1);
    localparam logic [PH_W-1:0] PH_HI_END = PH_W'(2 * BURST_LEN);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    // Terminal count of each divider (half-period minus one).
    localparam logic [CNT_W-1:0] DIV_LAST [4] = '{
        CNT_W'(RATE_HALF0 - 1),
        CNT_W'(RATE_HALF1 - 1),
        CNT_W'(RATE_HALF2 - 1),
        CNT_W'(RATE_HALF3 - 1)
    };

    logic [CNT_W-1:0] div_cnt [4];
    logic [3:0]       strobe;

    logic [PH_W-1:0]  phase  [NUM_CH];
    logic [1:0]       mode_q [NUM_CH];
    logic [1:0]       rate_q [NUM_CH];

    logic [NUM_CH-1:0] chg;
    logic [NUM_CH-1:0] sel_stb;
    logic [NUM_CH-1:0] burst_on;
    logic [PH_W-1:0]   ph_nxt [NUM_CH];

    // Shared dividers: wrap at the half-period and register a one-cycle strobe on the terminal count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                div_cnt[k] <= '0;
            end
            strobe <= '0;
        end else if (!enable) begin
            for (int k = 0; k < 4; k++) begin
                div_cnt[k] <= '0;
            end
            strobe <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (div_cnt[k] == DIV_LAST[k]) begin
                    div_cnt[k] <= '0;
                    strobe[k]  <= 1'b1;
                end else begin
                    div_cnt[k] <= div_cnt[k] + CNT_W'(1);
                    strobe[k]  <= 1'b0;
                end
            end
        end
    end

    // Per-channel decode: change detect, selected strobe and the burst phase lookahead.
    always_comb begin
        chg      = '0;
        sel_stb  = '0;
        burst_on = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            chg[c]     = (mode[2*c +: 2] != mode_q[c]) || (rate_sel[2*c +: 2] != rate_q[c]);
            sel_stb[c] = strobe[rate_sel[2*c +: 2]];
            ph_nxt[c]  = (phase[c] == PH_LAST) ? '0 : phase[c] + PH_W'(1);
            // High only on odd phases inside the first half of the burst cycle.
            burst_on[c] = (ph_nxt[c] < PH_HI_END) && ph_nxt[c][0];
        end
    end

    // Channel state: disable beats change detect, change detect beats a coincident strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                phase[c]  <= '0;
                mode_q[c] <= 2'b00;
                rate_q[c] <= 2'b00;
                led[c]    <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                // Stored copies follow the inputs even while disabled.
                mode_q[c] <= mode[2*c +: 2];
                rate_q[c] <= rate_sel[2*c +: 2];
                if (!enable) begin
                    phase[c] <= '0;
                    led[c]   <= 1'b0;
                end else if (chg[c]) begin
                    phase[c] <= '0;
                    led[c]   <= (mode[2*c +: 2] == MODE_ON);
                end else begin
                    case (mode[2*c +: 2])
                        MODE_OFF:   led[c] <= 1'b0;
                        MODE_ON:    led[c] <= 1'b1;
                        MODE_BLINK: begin
                            if (sel_stb[c]) begin
                                led[c] <= ~led[c];
                            end
                        end
                        MODE_BURST: begin
                            if (sel_stb[c]) begin
                                phase[c] <= ph_nxt[c];
                                led[c]   <= burst_on[c];
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_led_blink_multi.sv
// Self-checking bench for led_blink_multi with short divider half-periods.
// Latency: every edge is compared against a scoreboard entry queued when the stimulus is applied.
// Backpressure: none; the bench drives inputs freely between clock edges.
module tb_led_blink_multi;

    localparam int NUM_CH = 4;
    localparam int BL     = 2;
    localparam int HALF [4] = '{2, 3, 5, 8};

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] rate_sel;
    logic [7:0] mode;
    logic [3:0] led;

    int n_pass = 0;
    int n_tot  = 0;

    led_blink_multi #(
        .RATE_HALF0 (2),
        .RATE_HALF1 (3),
        .RATE_HALF2 (5),
        .RATE_HALF3 (8),
        .CNT_W      (8),
        .NUM_CH     (NUM_CH),
        .BURST_LEN  (BL)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .rate_sel (rate_sel),
        .mode     (mode),
        .led      (led)
    );

    always #5 clock = ~clock;

    // Reference model state: dividers tracked as "enabled edges since restart".
    int         m_age [4];
    logic [3:0] m_stb;
    logic [3:0] m_led;
    int         m_ph  [4];
    logic [1:0] m_pm  [4];
    logic [1:0] m_pr  [4];

    logic [3:0] sb_q [$];

    typedef struct {
        logic       en;
        logic [7:0] rs;
        logic [7:0] md;
        logic [3:0] exp_led;
    } vec_t;

    vec_t blink_tbl [8];

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_tot++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            m_age[k] = 0;
            m_ph[k]  = 0;
            m_pm[k]  = 2'b00;
            m_pr[k]  = 2'b00;
        end
        m_stb = '0;
        m_led = '0;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void model_edge();
        logic [3:0] nstb;
        logic [1:0] cm, cr;
        for (int c = 0; c < NUM_CH; c++) begin
            cm = mode[2*c +: 2];
            cr = rate_sel[2*c +: 2];
            if (!enable) begin
                m_led[c] = 1'b0;
                m_ph[c]  = 0;
            end else if (cm != m_pm[c] || cr != m_pr[c]) begin
                m_ph[c]  = 0;
                m_led[c] = (cm == 2'b01);
            end else if (cm == 2'b00) begin
                m_led[c] = 1'b0;
            end else if (cm == 2'b01) begin
                m_led[c] = 1'b1;
            end else if (cm == 2'b10) begin
                if (m_stb[cr]) m_led[c] = ~m_led[c];
            end else if (m_stb[cr]) begin
                m_ph[c]  = (m_ph[c] + 1) % (4 * BL);
                m_led[c] = (m_ph[c] < 2 * BL) && (m_ph[c] % 2 == 1);
            end
            m_pm[c] = cm;
            m_pr[c] = cr;
        end
        for (int k = 0; k < 4; k++) begin
            nstb[k]  = enable && ((m_age[k] % HALF[k]) == HALF[k] - 1);
            m_age[k] = enable ? m_age[k] + 1 : 0;
        end
        m_stb = nstb;
    endfunction

    // One clock: queue the model's expectation, let the edge pass, then compare.
    task automatic step();
        logic [3:0] exp;
        model_edge();
        sb_q.push_back(m_led);
        @(posedge clock);
        #1;
        exp = sb_q.pop_front();
        chk("model_led", int'(led), int'(exp));
    endtask

    task automatic run_blink(input string tag);
        for (int i = 0; i < 8; i++) begin
            enable   = blink_tbl[i].en;
            rate_sel = blink_tbl[i].rs;
            mode     = blink_tbl[i].md;
            step();
            chk(tag, int'(led), int'(blink_tbl[i].exp_led));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_seq [8] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1};
        logic [2:0] trace [80];
        logic [3:0] prev;
        int tog [4];
        int w;
        int pi;

        for (int i = 0; i < 8; i++) begin
            blink_tbl[i].en      = 1'b1;
            blink_tbl[i].rs      = 8'h00;
            blink_tbl[i].md      = 8'h02;
            blink_tbl[i].exp_led = exp_seq[i];
        end

        reset = 1'b1; enable = 1'b0; rate_sel = 8'h00; mode = 8'h00;
        model_reset();
        #2;
        chk("reset_led", int'(led), 0);
        @(posedge clock); @(posedge clock); #1;
        chk("reset_hold", int'(led), 0);
        reset = 1'b0;

        // Blink timing from reset.
        run_blink("blink_first");

        // Burst on ch1 at rate 1 while ch0 keeps blinking.
        mode = 8'h0E; rate_sel = 8'h04;
        w = 0;
        do begin step(); w++; end while (!led[1] && w < 10);
        chk("burst_rise", int'(led[1]), 1);
        for (int i = 1; i < 72; i++) begin
            step();
            pi = i % 24;
            chk("burst_pattern", int'(led[1]), int'((pi < 3) || (pi >= 6 && pi < 9)));
        end

        // Mode change mid-burst: 11 -> 01 -> 11.
        repeat (10) step();
        mode = 8'h06;
        step();
        chk("mode_to_on", int'(led[1]), 1);
        step(); step();
        mode = 8'h0E;
        step();
        chk("mode_to_burst", int'(led[1]), 0);
        w = 0;
        do begin step(); w++; end while (!led[1] && w < 3);
        chk("burst_restart", int'(led[1]), 1);
        step(); step();
        chk("burst_restart_hi", int'(led[1]), 1);
        step();
        chk("burst_restart_lo", int'(led[1]), 0);

        // Enable drop mid-blink, then re-enable.
        mode = 8'h02;
        repeat (3) step();
        enable = 1'b0;
        step();
        chk("enable_drop", int'(led), 0);
        step(); step();
        run_blink("blink_reenable");

        // Asynchronous reset while all LEDs are on.
        mode = 8'h55;
        step(); step();
        chk("all_on", int'(led), 15);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset", int'(led), 0);
        #1;
        reset = 1'b0;
        model_reset();
        run_blink("blink_post_reset");

        // Concurrency: four channels blinking at rates 0..3 from an aligned start.
        enable = 1'b0; mode = 8'hAA; rate_sel = 8'hE4;
        step(); step();
        enable = 1'b1;
        for (int c = 0; c < 4; c++) tog[c] = 0;
        prev = led;
        for (int i = 0; i < 80; i++) begin
            step();
            for (int c = 0; c < 4; c++) begin
                if (led[c] != prev[c]) tog[c]++;
            end
            prev = led;
            trace[i] = {led[3], led[1], led[0]};
        end
        chk_range("toggles_ch0", tog[0], 39, 41);
        chk_range("toggles_ch1", tog[1], 25, 27);
        chk_range("toggles_ch2", tog[2], 15, 17);
        chk_range("toggles_ch3", tog[3], 9, 11);

        // Same run again, but ch2 switches rate halfway; the other channels must repeat exactly.
        enable = 1'b0; rate_sel = 8'hE4;
        step(); step();
        enable = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (i == 40) rate_sel = 8'hC4;
            step();
            chk("independence", int'({led[3], led[1], led[0]}), int'(trace[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/led_blink_multi.md
Name: led_blink_multi

Overview:
- Parameterised multi-channel LED blinker. Successor of the single-LED, four-rate blinker.
- One shared bank of four rate dividers serves NUM_CH independent channels.
- Each channel selects its own rate and its own mode: off, on, blink, or burst.
- Sits between the board switch/register interface and the LED pins. All outputs are registered and glitch-free.

Parameters:
- RATE_HALF0, 125_000, half-period in clocks for rate 0 (100 Hz at 25 MHz).
- RATE_HALF1, 250_000, half-period for rate 1 (50 Hz).
- RATE_HALF2, 1_250_000, half-period for rate 2 (10 Hz).
- RATE_HALF3, 12_500_000, half-period for rate 3 (1 Hz).
- CNT_W, 32, divider counter width. Each RATE_HALFk must satisfy 2 <= RATE_HALFk <= 2^CNT_W-1.
- NUM_CH, 4, number of LED channels (>=1).
- BURST_LEN, 3, on-pulses per burst (>=1).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  global run. Low forces all LEDs off and clears dividers.
- rate_sel  input  2*NUM_CH  per channel, bits [2c+1:2c]: divider 0..3.
- mode  input  2*NUM_CH  per channel, bits [2c+1:2c]: 00 off, 01 on, 10 blink, 11 burst.
- led  output  NUM_CH  registered LED drive, bit c = channel c.

Behaviour:
- Reset, asynchronous, active-high: all divider counters = 0, all strobes = 0, led = 0, per-channel phase = 0, per-channel stored mode/rate = 0.
- Dividers, k = 0..3:
  - While enable = 1, counter k counts 0..RATE_HALFk-1 and wraps to 0.
  - strobe_k is a one-cycle pulse in the cycle where counter == RATE_HALFk-1.
  - While enable = 0, all counters are held at 0 and no strobes are produced.
- Per channel c: registered phase counter, width clog2(4*BURST_LEN). Registered copies of mode/rate_sel from the previous cycle.
- Change detect:
  - If mode_c or rate_sel_c differs from its stored copy, the next edge forces phase_c = 0 and led_c = 0.
  - Exception: if the new mode is 01, led_c = 1.
  - Change detect has priority over a coincident strobe.
- Mode 00: led_c = 0 on every edge.
- Mode 01: led_c = 1 on every edge while enable = 1.
- Mode 10 (blink): on each strobe of the selected divider, led_c toggles. Latency is 1 clock from the strobe cycle.
- Mode 11 (burst):
  - On each selected strobe, phase_c advances, wrapping at 4*BURST_LEN-1 -> 0.
  - led_c is registered as 1 when the new phase < 2*BURST_LEN and the new phase is odd; otherwise 0.
  - Result pattern: BURST_LEN pulses, each one half-period high and one half-period low, then a 2*BURST_LEN half-period pause. Repeats.
- enable = 0: next edge forces led = 0 and phase = 0 on all channels. Stored mode/rate copies still track the inputs.
- Rising enable: all channels restart from phase 0 and counter 0, so channels on the same rate are phase-aligned.
- Channels are fully independent; a change on one channel never disturbs another.

Test Plan (bench parameters RATE_HALF0..3 = 2,3,5,8, BURST_LEN = 2, NUM_CH = 4):
- Blink timing: reset, then enable = 1, ch0 mode = 10, rate = 0 -> led[0] rises at the 2nd edge after enable is sampled high, then toggles every 2 clocks (period 4). Other channels set to mode 00 stay at 0.
- Burst: ch1 mode = 11, rate = 1 -> led[1] half-periods of 3 clocks follow 1,0,1,0,0,0,0,0, repeating every 24 clocks. Check 3 full cycles.
- Enable drop: enable -> 0 mid-blink -> all led = 0 at the next edge. Re-enable -> identical timing to the blink-timing scenario, first rise 2 edges after enable.
- Mode change: ch1 switched 11 -> 01 mid-burst -> led[1] = 1 at the next edge. Switched back to 01 -> 11 -> led[1] = 0 at the next edge, and the burst restarts with its first high half-period 3 clocks later.
- Asynchronous reset: reset pulsed between clock edges while led = 4'b1111 -> led = 0 immediately, before the next edge. Held low with enable = 1 -> restarts per the blink-timing scenario.
- Concurrency: channels 0..3 in blink at rates 0..3, run 80 clocks -> toggle counts 40, 26, 16, 10 (±1). Changing ch2's rate mid-run leaves channels 0, 1 and 3 unchanged cycle-for-cycle.
